// File: rtl/cdb_arbiter.sv
// cdb_arbiter: merges ALU write-back results and MEM results onto one
// registered common data bus. ALU results cannot be back-pressured, so they
// are parked in a small FIFO. MEM results use a valid/ready handshake. A stall
// output throttles ALU dispatch before the FIFO can overflow.

module cdb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         Valid_ALU_CDB,
  input  logic [7:0]   ActiveMask_ALU_CDB,
  input  logic [2:0]   WarpID_ALU_CDB,
  input  logic [31:0]  Instr_ALU_CDB,
  input  logic [4:0]   Dst_ALU_CDB,
  input  logic [255:0] Dst_Data_ALU_CDB,
  input  logic [1:0]   ScbID_ALU_CDB,

  input  logic         Valid_MEM_CDB,
  output logic         Ready_CDB_MEM,
  input  logic [7:0]   ActiveMask_MEM_CDB,
  input  logic [2:0]   WarpID_MEM_CDB,
  input  logic [31:0]  Instr_MEM_CDB,
  input  logic [4:0]   Dst_MEM_CDB,
  input  logic [255:0] Dst_Data_MEM_CDB,
  input  logic [1:0]   ScbID_MEM_CDB,

  output logic         Valid_CDB,
  output logic [7:0]   ActiveMask_CDB,
  output logic [2:0]   WarpID_CDB,
  output logic [31:0]  Instr_CDB,
  output logic [4:0]   Dst_CDB,
  output logic [255:0] Dst_Data_CDB,
  output logic [1:0]   ScbID_CDB,
  output logic         RegWrite_CDB,
  output logic         Clear_Valid_CDB_Scb,
  output logic         Stall_CDB_OC,
  output logic         Overflow_CDB
);

  // Packed result layout: {mask, warp, instr, dst, data, scbid} = 306 bits.
  localparam int PW = 306;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 2);

  logic [PW-1:0] fifoMem_q [DEPTH];
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          lastGrantAlu_q, lastGrantAlu_d;
  logic          overflow_q, overflow_d;
  logic          outValid_q, outValid_d;
  logic [PW-1:0] outPayload_q, outPayload_d;

  logic [PW-1:0] aluPayload;
  logic [PW-1:0] memPayload;
  logic [PW-1:0] headPayload;
  logic          fifoEmpty;
  logic          fifoFull;
  logic          aluReq;
  logic          memReq;
  logic          grantAlu;
  logic          grantMem;
  logic          bypass;
  logic          pop;
  logic          pushReq;
  logic          push;
  logic          drop;

  assign aluPayload = {ActiveMask_ALU_CDB, WarpID_ALU_CDB, Instr_ALU_CDB,
                       Dst_ALU_CDB, Dst_Data_ALU_CDB, ScbID_ALU_CDB};
  assign memPayload = {ActiveMask_MEM_CDB, WarpID_MEM_CDB, Instr_MEM_CDB,
                       Dst_MEM_CDB, Dst_Data_MEM_CDB, ScbID_MEM_CDB};
  assign headPayload = fifoMem_q[rdPtr_q];

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == FULL_CNT);

  // The ALU side requests with the FIFO head, or with the live input when the
  // FIFO is empty. On a tie the side that did not win last time gets the bus.
  assign aluReq   = !fifoEmpty || Valid_ALU_CDB;
  assign memReq   = Valid_MEM_CDB;
  assign grantAlu = aluReq && (!memReq || !lastGrantAlu_q);
  assign grantMem = memReq && (!aluReq || lastGrantAlu_q);

  // Bypass only happens from an empty FIFO; anything not bypassed is queued,
  // unless the FIFO is full and nothing leaves this cycle, in which case the
  // result is lost and the sticky overflow flag records it.
  assign bypass  = grantAlu && fifoEmpty;
  assign pop     = grantAlu && !fifoEmpty;
  assign pushReq = Valid_ALU_CDB && !bypass;
  assign push    = pushReq && (!fifoFull || pop);
  assign drop    = pushReq && fifoFull && !pop;

  // Next-state for FIFO bookkeeping, arbitration history and the CDB register.
  always_comb begin
    rdPtr_d        = rdPtr_q;
    wrPtr_d        = wrPtr_q;
    count_d        = count_q;
    lastGrantAlu_d = lastGrantAlu_q;
    overflow_d     = overflow_q || drop;
    outValid_d     = 1'b0;
    outPayload_d   = outPayload_q;

    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    if (grantAlu) begin
      lastGrantAlu_d = 1'b1;
      outValid_d     = 1'b1;
      outPayload_d   = fifoEmpty ? aluPayload : headPayload;
    end else if (grantMem) begin
      lastGrantAlu_d = 1'b0;
      outValid_d     = 1'b1;
      outPayload_d   = memPayload;
    end
  end

  // Control and output registers; reset empties the FIFO and lets ALU win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q        <= '0;
      wrPtr_q        <= '0;
      count_q        <= '0;
      lastGrantAlu_q <= 1'b0;
      overflow_q     <= 1'b0;
      outValid_q     <= 1'b0;
      outPayload_q   <= '0;
    end else begin
      rdPtr_q        <= rdPtr_d;
      wrPtr_q        <= wrPtr_d;
      count_q        <= count_d;
      lastGrantAlu_q <= lastGrantAlu_d;
      overflow_q     <= overflow_d;
      outValid_q     <= outValid_d;
      outPayload_q   <= outPayload_d;
    end
  end

  // FIFO storage needs no reset: the pointers and count decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem_q[wrPtr_q] <= aluPayload;
    end
  end

  assign Valid_CDB           = outValid_q;
  assign RegWrite_CDB        = outValid_q;
  assign Clear_Valid_CDB_Scb = outValid_q;
  assign Overflow_CDB        = overflow_q;
  assign {ActiveMask_CDB, WarpID_CDB, Instr_CDB,
          Dst_CDB, Dst_Data_CDB, ScbID_CDB} = outPayload_q;

  // Handshake and throttle are held low while reset is applied.
  assign Ready_CDB_MEM = !rst && grantMem;
  assign Stall_CDB_OC  = !rst && (count_q >= STALL_CNT);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: a behavioural model of the FIFO and round-robin
// arbitration predicts every CDB result; predictions go into a scoreboard
// queue and are popped when the DUT presents a valid CDB result.

module tb_cdb_arbiter;

  localparam int DEPTH = 4;
  localparam int PW = 306;

  logic         clk = 1'b0;
  logic         rst;
  logic         Valid_ALU_CDB;
  logic [7:0]   ActiveMask_ALU_CDB;
  logic [2:0]   WarpID_ALU_CDB;
  logic [31:0]  Instr_ALU_CDB;
  logic [4:0]   Dst_ALU_CDB;
  logic [255:0] Dst_Data_ALU_CDB;
  logic [1:0]   ScbID_ALU_CDB;
  logic         Valid_MEM_CDB;
  logic         Ready_CDB_MEM;
  logic [7:0]   ActiveMask_MEM_CDB;
  logic [2:0]   WarpID_MEM_CDB;
  logic [31:0]  Instr_MEM_CDB;
  logic [4:0]   Dst_MEM_CDB;
  logic [255:0] Dst_Data_MEM_CDB;
  logic [1:0]   ScbID_MEM_CDB;
  logic         Valid_CDB;
  logic [7:0]   ActiveMask_CDB;
  logic [2:0]   WarpID_CDB;
  logic [31:0]  Instr_CDB;
  logic [4:0]   Dst_CDB;
  logic [255:0] Dst_Data_CDB;
  logic [1:0]   ScbID_CDB;
  logic         RegWrite_CDB;
  logic         Clear_Valid_CDB_Scb;
  logic         Stall_CDB_OC;
  logic         Overflow_CDB;

  logic [PW-1:0] cdbPayload;
  assign cdbPayload = {ActiveMask_CDB, WarpID_CDB, Instr_CDB, Dst_CDB, Dst_Data_CDB, ScbID_CDB};

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  cdb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .Valid_ALU_CDB       (Valid_ALU_CDB),
    .ActiveMask_ALU_CDB  (ActiveMask_ALU_CDB),
    .WarpID_ALU_CDB      (WarpID_ALU_CDB),
    .Instr_ALU_CDB       (Instr_ALU_CDB),
    .Dst_ALU_CDB         (Dst_ALU_CDB),
    .Dst_Data_ALU_CDB    (Dst_Data_ALU_CDB),
    .ScbID_ALU_CDB       (ScbID_ALU_CDB),
    .Valid_MEM_CDB       (Valid_MEM_CDB),
    .Ready_CDB_MEM       (Ready_CDB_MEM),
    .ActiveMask_MEM_CDB  (ActiveMask_MEM_CDB),
    .WarpID_MEM_CDB      (WarpID_MEM_CDB),
    .Instr_MEM_CDB       (Instr_MEM_CDB),
    .Dst_MEM_CDB         (Dst_MEM_CDB),
    .Dst_Data_MEM_CDB    (Dst_Data_MEM_CDB),
    .ScbID_MEM_CDB       (ScbID_MEM_CDB),
    .Valid_CDB           (Valid_CDB),
    .ActiveMask_CDB      (ActiveMask_CDB),
    .WarpID_CDB          (WarpID_CDB),
    .Instr_CDB           (Instr_CDB),
    .Dst_CDB             (Dst_CDB),
    .Dst_Data_CDB        (Dst_Data_CDB),
    .ScbID_CDB           (ScbID_CDB),
    .RegWrite_CDB        (RegWrite_CDB),
    .Clear_Valid_CDB_Scb (Clear_Valid_CDB_Scb),
    .Stall_CDB_OC        (Stall_CDB_OC),
    .Overflow_CDB        (Overflow_CDB)
  );

  logic [PW-1:0] expQ[$];
  logic [PW-1:0] modelFifo[$];
  logic          modelLastAlu;
  logic          modelOverflow;
  logic          memHeld;
  logic [PW-1:0] memHeldPayload;
  int            memSeq;
  int            assertCount = 0;
  int            failCount = 0;

  task automatic checkOutput(input string tag, input logic [PW-1:0] actual, input logic [PW-1:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [PW-1:0] mkPayload(input logic [4:0] dst, input logic [31:0] lane0, input logic [7:0] tag);
    logic [255:0] data;
    data[31:0] = lane0;
    for (int i = 1; i < 8; i++) data[32*i +: 32] = $urandom;
    return {tag, tag[2:0], 8'hA5, 16'(tag), 3'b0, dst, dst, data, tag[1:0]};
  endfunction

  // One clock cycle: drive inputs, predict and check the combinational
  // outputs before the edge, then check the registered outputs after it.
  task automatic applyStimulus(input logic rstIn, input logic aluV, input logic [PW-1:0] aluP, input logic memOffer);
    logic [PW-1:0] outP;
    logic          aluReq, memReq, gAlu, gMem, expValid;
    int            sizeBefore;
    outP = '0;
    rst = rstIn;
    Valid_ALU_CDB = aluV;
    {ActiveMask_ALU_CDB, WarpID_ALU_CDB, Instr_ALU_CDB, Dst_ALU_CDB, Dst_Data_ALU_CDB, ScbID_ALU_CDB} = aluP;
    if (!memHeld && memOffer) begin
      memSeq++;
      memHeldPayload = mkPayload(5'(memSeq), 32'hE000_0000 + 32'(memSeq), 8'(memSeq + 100));
    end
    Valid_MEM_CDB = memHeld || memOffer;
    {ActiveMask_MEM_CDB, WarpID_MEM_CDB, Instr_MEM_CDB, Dst_MEM_CDB, Dst_Data_MEM_CDB, ScbID_MEM_CDB} = memHeldPayload;
    @(negedge clk);
    if (rstIn) begin
      checkOutput("ready_in_reset", PW'(Ready_CDB_MEM), '0);
      checkOutput("stall_in_reset", PW'(Stall_CDB_OC), '0);
      modelFifo.delete();
      expQ.delete();
      modelLastAlu = 1'b0;
      modelOverflow = 1'b0;
      memHeld = 1'b0;
      expValid = 1'b0;
    end else begin
      sizeBefore = modelFifo.size();
      aluReq = (sizeBefore != 0) || aluV;
      memReq = Valid_MEM_CDB;
      gAlu = aluReq && (!memReq || !modelLastAlu);
      gMem = memReq && !gAlu;
      expValid = gAlu || gMem;
      checkOutput("ready", PW'(Ready_CDB_MEM), PW'(gMem));
      checkOutput("stall", PW'(Stall_CDB_OC), PW'(sizeBefore >= DEPTH - 2));
      if (gAlu) begin
        outP = (sizeBefore != 0) ? modelFifo.pop_front() : aluP;
        modelLastAlu = 1'b1;
      end else if (gMem) begin
        outP = memHeldPayload;
        modelLastAlu = 1'b0;
      end
      if (aluV && !(gAlu && sizeBefore == 0)) begin
        if (sizeBefore == DEPTH && !gAlu) modelOverflow = 1'b1;
        else modelFifo.push_back(aluP);
      end
      if (expValid) expQ.push_back(outP);
      memHeld = Valid_MEM_CDB && !gMem;
    end
    @(posedge clk);
    #1;
    checkOutput("cdb_valid", PW'(Valid_CDB), PW'(expValid));
    checkOutput("regwrite", PW'(RegWrite_CDB), PW'(expValid));
    checkOutput("clear_scb", PW'(Clear_Valid_CDB_Scb), PW'(expValid));
    checkOutput("overflow", PW'(Overflow_CDB), PW'(modelOverflow));
    if (rstIn) begin
      checkOutput("payload_reset", cdbPayload, '0);
    end else if (Valid_CDB === 1'b1 && expQ.size() != 0) begin
      checkOutput("cdb_payload", cdbPayload, expQ.pop_front());
    end
  endtask

  // Idle both sources until the model has nothing left to emit, then one more idle cycle.
  task automatic drain();
    int n = 0;
    while ((modelFifo.size() != 0 || memHeld) && n < 20) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      n++;
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
  endtask

  // Main sequence of directed scenarios.
  initial begin
    memHeld = 1'b0;
    memHeldPayload = '0;
    memSeq = 0;
    modelLastAlu = 1'b0;
    modelOverflow = 1'b0;

    $display("[TB] reset with both sources valid");
    repeat (2) applyStimulus(1'b1, 1'b1, mkPayload(5'd1, 32'h1, 8'h01), 1'b1);
    applyStimulus(1'b0, 1'b1, mkPayload(5'd2, 32'h2, 8'h02), 1'b1);
    drain();

    $display("[TB] ALU only, back to back");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, mkPayload(5'd5, 32'h0000_0010, 8'(10 + i)), 1'b0);
    drain();

    $display("[TB] contention until FIFO full and overflow");
    for (int i = 0; i < 11; i++) applyStimulus(1'b0, 1'b1, mkPayload(5'(i), 32'h100 + 32'(i), 8'(20 + i)), 1'b1);

    $display("[TB] reset with FIFO full");
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    drain();

    $display("[TB] pointer wrap under contention");
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, (i % 3) != 2, mkPayload(5'(i), $urandom, 8'(40 + i)), 1'b1);
    drain();

    $display("[TB] sustained contention then drain");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, mkPayload(5'(i + 8), $urandom, 8'(60 + i)), 1'b1);
    drain();

    checkOutput("scoreboard_empty", PW'(expQ.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
